routine_sequencer: RTL and testbench

Top-level controller for the light-routine datapath. Divides the board clock into a routine step tick and owns the single 47-bit board output bus. Clock-enables and resets one routine at a time, and advances between routines on a pushbutton press or an automatic dwell timeout. Between routines it inserts a blanking interval. Sits between the NUM_RTN routine instances and the LED/seven-segment pins.

---
 rtl/routine_sequencer.sv | 177 +++++++++++++++++
 tb/tb_routine_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/routine_sequencer.sv
// Routine sequencer: divides the board clock into step ticks, runs one routine at a time
// and owns the shared 47-bit board bus, inserting a blank interval between routines.
module routine_sequencer #(
    parameter int NUM_RTN     = 4,
    parameter int TICK_DIV    = 25000000,
    parameter int DWELL_TICKS = 64,
    parameter int BLANK_TICKS = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         NextBtn,
    input  logic                         AutoMode,
    input  logic [47*NUM_RTN-1:0]        RtnBus,
    output logic [NUM_RTN-1:0]           RtnEnable,
    output logic [NUM_RTN-1:0]           RtnReset,
    output logic [46:0]                  OutputBus,
    output logic [$clog2(NUM_RTN)-1:0]   ActiveRtn,
    output logic                         Tick
);
    localparam int RW  = $clog2(NUM_RTN);
    localparam int DW  = $clog2(TICK_DIV);
    localparam int DWW = $clog2(DWELL_TICKS + 1);
    localparam int BW  = $clog2(BLANK_TICKS + 1);

    localparam logic [46:0]    BLANK_PAT  = 47'h000_0FFF_FFFF;
    localparam logic [DW-1:0]  DIV_LAST   = DW'(TICK_DIV - 1);
    localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_TICKS - 1);
    localparam logic [BW-1:0]  BLANK_LAST = BW'(BLANK_TICKS - 1);
    localparam logic [RW-1:0]  RTN_LAST   = RW'(NUM_RTN - 1);

    typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, BLANK = 2'd2} state_e;

    function automatic logic [NUM_RTN-1:0] one_hot(input logic [RW-1:0] idx);
        one_hot = {{(NUM_RTN-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic [RW-1:0]      active_q, active_d;
    logic [DW-1:0]      div_q, div_d, div_inc_s;
    logic [DWW-1:0]     dwell_q, dwell_d;
    logic [BW-1:0]      blank_q, blank_d;
    logic               btn_s1_q, btn_s2_q, btn_s3_q;
    logic               press_s, advance_s;
    logic               tick_q, tick_d;
    logic [NUM_RTN-1:0] rtn_en_q, rtn_en_d, rtn_rst_q, rtn_rst_d;
    logic [46:0]        out_q, out_d, rtn_sel_s;

    // State, counters, button synchronizer and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= LOAD;
            start_q   <= 1'b1;
            active_q  <= {RW{1'b0}};
            div_q     <= {DW{1'b0}};
            dwell_q   <= {DWW{1'b0}};
            blank_q   <= {BW{1'b0}};
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            btn_s3_q  <= 1'b0;
            tick_q    <= 1'b0;
            rtn_en_q  <= {NUM_RTN{1'b0}};
            rtn_rst_q <= {NUM_RTN{1'b1}};
            out_q     <= BLANK_PAT;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            active_q  <= active_d;
            div_q     <= div_d;
            dwell_q   <= dwell_d;
            blank_q   <= blank_d;
            btn_s1_q  <= NextBtn;
            btn_s2_q  <= btn_s1_q;
            btn_s3_q  <= btn_s2_q;
            tick_q    <= tick_d;
            rtn_en_q  <= rtn_en_d;
            rtn_rst_q <= rtn_rst_d;
            out_q     <= out_d;
        end
    end

    // Press detect, advance condition, divider increment and routine bus mux.
    always_comb begin
        press_s   = btn_s2_q & ~btn_s3_q;
        advance_s = press_s | (AutoMode & tick_q & (dwell_q == DWELL_LAST));
        if (div_q == DIV_LAST) begin
            div_inc_s = {DW{1'b0}};
        end else begin
            div_inc_s = div_q + DW'(1);
        end
        rtn_sel_s = 47'h0;
        for (int i = 0; i < NUM_RTN; i++) begin
            rtn_sel_s = rtn_sel_s | (RtnBus[47*i +: 47] & {47{active_q == RW'(i)}});
        end
    end

    // Next-state logic; the first post-reset cycle lingers in LOAD so LOAD is visible once.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        active_d = active_q;
        div_d    = div_q;
        dwell_d  = dwell_q;
        blank_d  = blank_q;
        case (state_q)
            LOAD: begin
                div_d   = {DW{1'b0}};
                dwell_d = {DWW{1'b0}};
                if (start_q) begin
                    state_d = LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                div_d = div_inc_s;
                if (advance_s) begin
                    state_d  = BLANK;
                    div_d    = {DW{1'b0}};
                    blank_d  = {BW{1'b0}};
                    if (active_q == RTN_LAST) begin
                        active_d = {RW{1'b0}};
                    end else begin
                        active_d = active_q + RW'(1);
                    end
                end else if (tick_q && AutoMode) begin
                    dwell_d = dwell_q + DWW'(1);
                end else begin
                    dwell_d = dwell_q;
                end
            end
            BLANK: begin
                div_d = div_inc_s;
                if (tick_q) begin
                    blank_d = blank_q + BW'(1);
                    if (blank_q == BLANK_LAST) begin
                        state_d = LOAD;
                    end else begin
                        state_d = BLANK;
                    end
                end else begin
                    blank_d = blank_q;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Output next values follow the next state so the ports line up with the state register.
    always_comb begin
        tick_d = (state_d != LOAD) && (div_d == DIV_LAST);
        if (state_d == LOAD) begin
            rtn_rst_d = one_hot(active_d);
            rtn_en_d  = one_hot(active_d);
        end else if ((state_d == RUN) && tick_d) begin
            rtn_rst_d = {NUM_RTN{1'b0}};
            rtn_en_d  = one_hot(active_d);
        end else begin
            rtn_rst_d = {NUM_RTN{1'b0}};
            rtn_en_d  = {NUM_RTN{1'b0}};
        end
        if (state_q == RUN) begin
            out_d = rtn_sel_s;
        end else begin
            out_d = BLANK_PAT;
        end
    end

    assign RtnEnable = rtn_en_q;
    assign RtnReset  = rtn_rst_q;
    assign OutputBus = out_q;
    assign ActiveRtn = active_q;
    assign Tick      = tick_q;

endmodule

// File: tb/tb_routine_sequencer.sv
// Bench for routine_sequencer: directed steps plus random stimulus checked every cycle
// against a phase/elapsed-time reference model.
module tb_routine_sequencer;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int BT = 2;
    localparam logic [46:0] BLANK_PAT = 47'h000_0FFF_FFFF;

    logic            Clock    = 1'b0;
    logic            Reset    = 1'b1;
    logic            NextBtn  = 1'b0;
    logic            AutoMode = 1'b0;
    logic [47*N-1:0] RtnBus   = '0;
    logic [N-1:0]    RtnEnable, RtnReset;
    logic [46:0]     OutputBus;
    logic [1:0]      ActiveRtn;
    logic            Tick;

    routine_sequencer #(.NUM_RTN(N), .TICK_DIV(TD), .DWELL_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .Clock(Clock), .Reset(Reset), .NextBtn(NextBtn), .AutoMode(AutoMode),
        .RtnBus(RtnBus), .RtnEnable(RtnEnable), .RtnReset(RtnReset),
        .OutputBus(OutputBus), .ActiveRtn(ActiveRtn), .Tick(Tick)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0=held in reset/first cycle, 1=LOAD, 2=RUN, 3=BLANK.
    int          m_phase, m_active, m_elapsed, m_dwell, m_bticks;
    bit          m_h1, m_h2, m_h3;
    logic [46:0] m_out;
    bit          fixed_bus = 1'b0;

    function automatic bit m_tick();
        return (m_phase >= 2) && ((m_elapsed % TD) == TD - 1);
    endfunction

    function automatic logic [N-1:0] hot(input int idx);
        logic [N-1:0] h;
        h = '0;
        h[idx] = 1'b1;
        return h;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        bit tk;
        logic [N-1:0] en, rs;
        tk = m_tick();
        en = '0;
        rs = '0;
        if (m_phase == 0) rs = '1;
        if (m_phase == 1) begin
            rs = hot(m_active);
            en = hot(m_active);
        end
        if (m_phase == 2 && tk) en = hot(m_active);
        check("Tick", 64'(Tick), 64'(tk));
        check("RtnEnable", 64'(RtnEnable), 64'(en));
        check("RtnReset", 64'(RtnReset), 64'(rs));
        check("OutputBus", 64'(OutputBus), 64'(m_out));
        check("ActiveRtn", 64'(ActiveRtn), 64'(m_active));
    endtask

    task automatic model_reset();
        m_phase = 0; m_active = 0; m_elapsed = 0; m_dwell = 0; m_bticks = 0;
        m_h1 = 1'b0; m_h2 = 1'b0; m_h3 = 1'b0;
        m_out = BLANK_PAT;
    endtask

    // One clock: randomize the routine bus, advance the model, then compare after the edge.
    task automatic step();
        logic [191:0] wide;
        logic [46:0]  nout;
        bit tk, press;
        if (!fixed_bus) begin
            wide = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            RtnBus = wide[47*N-1:0];
        end
        tk    = m_tick();
        press = m_h2 && !m_h3;
        nout  = (m_phase == 2) ? RtnBus[47*m_active +: 47] : BLANK_PAT;
        case (m_phase)
            0: m_phase = 1;
            1: begin m_phase = 2; m_elapsed = 0; m_dwell = 0; end
            2: begin
                if (press || (AutoMode && tk && m_dwell == DT - 1)) begin
                    m_phase = 3; m_elapsed = 0; m_bticks = 0;
                    m_active = (m_active + 1) % N;
                end else begin
                    m_elapsed++;
                    if (tk && AutoMode) m_dwell++;
                end
            end
            default: begin
                if (tk) m_bticks++;
                if (tk && m_bticks == BT) m_phase = 1;
                else m_elapsed++;
            end
        endcase
        m_out = nout;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = NextBtn;
        @(posedge Clock);
        #1;
        check_all();
    endtask

    // Asynchronous reset away from any clock edge, checked before the next edge.
    task automatic apply_reset();
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check("rst_out", 64'(OutputBus), 64'(BLANK_PAT));
        check("rst_active", 64'(ActiveRtn), 64'(0));
        check("rst_rtnreset", 64'(RtnReset), 64'(4'b1111));
        check("rst_rtnenable", 64'(RtnEnable), 64'(4'b0000));
        check_all();
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        model_reset();
        apply_reset();

        // Load and cadence in manual mode
        step();
        check("load_rtnreset", 64'(RtnReset), 64'(4'b0001));
        check("load_rtnenable", 64'(RtnEnable), 64'(4'b0001));
        repeat (100) step();
        check("no_advance", 64'(ActiveRtn), 64'(0));

        // Manual advance, button held 20 cycles
        NextBtn = 1'b1;
        repeat (3) step();
        check("manual_adv", 64'(ActiveRtn), 64'(1));
        repeat (17) step();
        NextBtn = 1'b0;
        repeat (30) step();
        check("single_adv", 64'(ActiveRtn), 64'(1));

        // Press during BLANK is discarded
        NextBtn = 1'b1;
        repeat (3) step();
        check("adv_to_2", 64'(ActiveRtn), 64'(2));
        NextBtn = 1'b0; step();
        NextBtn = 1'b1; repeat (2) step();
        NextBtn = 1'b0;
        repeat (20) step();
        check("blank_press_ignored", 64'(ActiveRtn), 64'(2));

        // Mux of routine 2 and blanking afterwards
        fixed_bus = 1'b1;
        RtnBus = '0;
        RtnBus[94 +: 47] = 47'h5A5A_A5A5_A5A5;
        repeat (2) step();
        check("mux_slice2", 64'(OutputBus), 64'(47'h5A5A_A5A5_A5A5));
        NextBtn = 1'b1;
        repeat (4) step();
        check("mux_blank", 64'(OutputBus), 64'(BLANK_PAT));
        NextBtn = 1'b0;
        fixed_bus = 1'b0;

        // Auto wrap from routine 3
        AutoMode = 1'b1;
        for (int i = 0; i < 40 && RtnReset == 4'b0000; i++) step();
        check("wrap_load", 64'(RtnReset), 64'(4'b1000));
        repeat (12) step();
        check("wrap_still3", 64'(ActiveRtn), 64'(3));
        step();
        check("wrap_to0", 64'(ActiveRtn), 64'(0));
        check("wrap_blank_en", 64'(RtnEnable), 64'(4'b0000));
        repeat (7) step();
        check("wrap_blank_rst", 64'(RtnReset), 64'(4'b0000));
        step();
        check("wrap_reload", 64'(RtnReset), 64'(4'b0001));

        // Press coinciding with the dwell-expiry tick
        repeat (10) step();
        NextBtn = 1'b1;
        repeat (3) step();
        check("coincide_adv", 64'(ActiveRtn), 64'(1));
        AutoMode = 1'b0;
        NextBtn = 1'b0;
        repeat (20) step();
        check("coincide_single", 64'(ActiveRtn), 64'(1));

        // Random button and mode activity
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7, 0) == 0) NextBtn = ~NextBtn;
            if ($urandom_range(39, 0) == 0) AutoMode = ~AutoMode;
            step();
        end

        // Async reset mid-RUN at routine 2
        apply_reset();
        AutoMode = 1'b0;
        NextBtn = 1'b0;
        repeat (2) step();
        NextBtn = 1'b1; repeat (3) step();
        NextBtn = 1'b0; repeat (12) step();
        NextBtn = 1'b1; repeat (3) step();
        NextBtn = 1'b0; repeat (14) step();
        check("pre_reset_active", 64'(ActiveRtn), 64'(2));
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(5, 0) == 0) NextBtn = ~NextBtn;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
